boot_sequencer: RTL

Synthesizable program-load and run controller for the single-cycle core.
- Load phase: streams an instruction image over a valid/ready interface into memory port A at a configurable base, then appends an end-of-program sentinel word.
- Run phase: releases core reset and supervises execution with a cycle watchdog and sentinel-fetch halt detection.
- It sits between an image source (UART/ROM streamer) and the Mem4K A port / MicroarchiSC reset, in both FPGA builds and simulation.

---
 rtl/boot_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/boot_sequencer.sv
// Program-load and run controller. It streams an instruction image into memory port A,
// appends a sentinel word, then releases the core under a watchdog with halt detection.
`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif

module boot_sequencer #(
    parameter int unsigned   DW          = 32,
    parameter int unsigned   AW          = 32,
    parameter int unsigned   BASE        = 2048,
    parameter int unsigned   STEP        = 4,
    parameter int unsigned   DEPTH       = 1024,
    parameter int unsigned   RUN_CYCLES  = 512,
    parameter logic [DW-1:0] END_WORD    = 32'h0000FFFF,
    parameter bit            HALT_DETECT = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           s_valid,
    input  logic [DW-1:0]                  s_data,
    input  logic                           s_last,
    output logic                           s_ready,
    output logic                           mem_enwr,
    output logic [AW-1:0]                  mem_abus,
    output logic [DW-1:0]                  mem_dbusw,
    output logic                           core_rst,
    input  logic [AW-1:0]                  fetch_addr,
    input  logic [DW-1:0]                  fetch_instr,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [$clog2(DEPTH+1)-1:0]     words_loaded,
    output logic [31:0]                    cycles
);

    localparam int unsigned WLW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, TERM, SETTLE, RUN, DONE} state_t;

    localparam logic [1:0]     ST_NONE       = 2'b00;
    localparam logic [1:0]     ST_HALTED     = 2'b01;
    localparam logic [1:0]     ST_TIMEOUT    = 2'b10;
    localparam logic [1:0]     ST_OVERFLOW   = 2'b11;
    localparam logic [AW-1:0]  BASE_ADDR     = AW'(BASE);
    localparam logic [AW-1:0]  STEP_ADDR     = AW'(STEP);
    // Index of the last image slot; the one after it is reserved for the sentinel.
    localparam logic [WLW-1:0] LAST_SLOT     = WLW'(DEPTH - 2);
    localparam logic [31:0]    WATCHDOG_LAST = 32'(RUN_CYCLES - 1);

    state_t        state;
    logic [AW-1:0] next_addr;
    logic          settle_hold;
    logic          accept;
    logic          halt_hit;
    logic          timeout_hit;
    logic          unused_fetch_addr;

    assign accept            = s_valid & s_ready;
    assign halt_hit          = HALT_DETECT && (fetch_instr == END_WORD);
    assign timeout_hit       = (cycles == WATCHDOG_LAST);
    assign unused_fetch_addr = ^fetch_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            next_addr    <= BASE_ADDR;
            settle_hold  <= 1'b0;
            core_rst     <= 1'b1;
            s_ready      <= 1'b0;
            mem_enwr     <= `MM_ENB_R;
            mem_abus     <= BASE_ADDR;
            mem_dbusw    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            status       <= ST_NONE;
            words_loaded <= '0;
            cycles       <= '0;
        end else begin
            // NOTE: write strobe defaults back to read every cycle, so any write lasts exactly one cycle.
            mem_enwr <= `MM_ENB_R;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        next_addr    <= BASE_ADDR;
                        words_loaded <= '0;
                        cycles       <= '0;
                        status       <= ST_NONE;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        core_rst     <= 1'b1;
                        s_ready      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_enwr     <= `MM_ENB_W;
                        mem_abus     <= next_addr;
                        mem_dbusw    <= s_data;
                        next_addr    <= next_addr + STEP_ADDR;
                        words_loaded <= words_loaded + WLW'(1);
                        if (s_last) begin
                            state   <= TERM;
                            s_ready <= 1'b0;
                        end else if (words_loaded == LAST_SLOT) begin
                            state   <= DONE;
                            s_ready <= 1'b0;
                            status  <= ST_OVERFLOW;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                TERM: begin
                    mem_enwr    <= `MM_ENB_W;
                    mem_abus    <= next_addr;
                    mem_dbusw   <= END_WORD;
                    settle_hold <= 1'b1;
                    state       <= SETTLE;
                end
                SETTLE: begin
                    // First cycle here still shows the sentinel write; the second is the quiet settle cycle.
                    if (settle_hold) begin
                        settle_hold <= 1'b0;
                    end else begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycles != 32'hFFFF_FFFF) begin
                        cycles <= cycles + 32'd1;
                    end
                    if (halt_hit || timeout_hit) begin
                        state    <= DONE;
                        status   <= halt_hit ? ST_HALTED : ST_TIMEOUT;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
